ts_req_scheduler: RTL and testbench
===================================

// Module: ts_req_scheduler
// PURPOSE
//  Shares one event_timestamper among N_REQ requesters (e.g. MAC/UDP ports). Allocates free IDs
//  for start events and round-robin arbitrates the start and end ports. Routes each result back
//  to the requester that owns the ID, and frees the ID on result handshake.
//  Sits between the requesters and event_timestamper. The timestamper is not modified.
// PARAMETERS
//  N_REQ  4  number of requesters (>=2)
//  ID_W   3  ID width; 2**ID_W in-flight events max
//  TS_W   8  timestamp width (matches timestamper)
// PORTS
//  clk               in   1            clock
//  rst               in   1            synchronous, active-high reset
//  req_start_valid   in   N_REQ        per-requester start request
//  req_start_ready   out  N_REQ        start accepted (one-hot or zero)
//  req_start_id      out  ID_W         ID allocated to the accepted requester (valid with ready)
//  req_end_valid     in   N_REQ        per-requester end request
//  req_end_id        in   N_REQ*ID_W   end ID, requester i at [i*ID_W +: ID_W]
//  req_end_ready     out  N_REQ        end accepted (one-hot or zero)
//  res_valid         out  N_REQ        result valid to owner requester (one-hot or zero)
//  res_ready         in   N_REQ        per-requester result ready
//  res_id / res_start_ts / res_end_ts / res_delta  out  ID_W/TS_W/TS_W/TS_W  shared result bus
//  ts_start_valid/ready/id, ts_end_valid/ready/id  out/in/out  1/1/ID_W  to timestamper
//  ts_out_valid/ready  in/out  1  from timestamper
//  ts_out_id/start_ts/end_ts/delta  in  ID_W/TS_W  from timestamper
//  sched_err         out  1            illegal-end pulse (TS_SCHED_CHECK_EN only; else tied 0)
// BEHAVIOUR
//  - Reset: busy[]=0, owner[]=0, both RR pointers=0. All ready/valid outputs and sched_err are 0.
//  - Start path (0 latency, combinational):
//    - alloc_id = lowest index with busy==0; have_free = |~busy.
//    - The start RR arbiter picks g among req_start_valid when have_free, starting at ptr_s.
//    - ts_start_valid = have_free && |req_start_valid; ts_start_id = alloc_id.
//    - req_start_ready[g] = ts_start_ready; req_start_id = alloc_id.
//    - On handshake: busy[alloc_id]<=1, owner[alloc_id]<=g, ptr_s<=g+1 (mod N_REQ).
//  - Full (all busy): ts_start_valid=0 and all req_start_ready=0. Requesters hold valid.
//  - End path: an independent RR arbiter (ptr_e) over req_end_valid forwards the winner's id
//    to ts_end_*. req_end_ready[w]=ts_end_ready. ptr_e<=w+1 on handshake.
//  - Result path: o = owner[ts_out_id].
//    - res_valid[o] = ts_out_valid; ts_out_ready = res_ready[o].
//    - Data buses pass straight through.
//    - On handshake: busy[ts_out_id]<=0.
//  - Simultaneous free and alloc in one cycle: alloc uses the pre-free busy vector. A freed ID is
//    reusable from the next cycle. Free and set never hit the same ID.
//  - Arbiters are not fair across paths. A waiting requester gets a grant within N_REQ handshakes.
//  - Requesters must hold valid and data stable until ready (AXI-style). No combinational path
//    from *_ready inputs to *_valid outputs.
//  - Reset mid-operation: all state is cleared at once, and in-flight IDs are forgotten. The
//    timestamper shares rst, so its state is cleared too.
// CONFIGURATION
//  TS_SCHED_CHECK_EN defined:
//    - An end whose id is not busy, or whose owner != requester, is still accepted
//      (req_end_ready=1). It is not forwarded (ts_end_valid=0 that cycle) and sched_err pulses
//      for 1 cycle.
//    - ptr_e still advances.
//  TS_SCHED_CHECK_EN undefined: end requests are forwarded unchecked; sched_err tied 0.
// STRUCTURE
//  - Package ts_sched_pkg: id_t, req_idx_t (logic [$clog2(N_REQ)-1:0]), ts_t, and the
//    result_t struct {id, start_ts, end_ts, delta}.
//  - Sub-module ts_rr_arb #(N) (req, ptr -> onehot gnt, idx). It is instantiated twice
//    (start, end).
//  - The free-ID priority encoder and owner table stay inline.
// TESTING  (N_REQ=4, ID_W=3, TS_W=8, real event_timestamper as downstream)
//  1. Req2 start alone -> req_start_ready[2]=1, req_start_id=0. Req2 end id=0 ~10 cycles later
//     -> res_valid=4'b0100, res_id=0, res_delta=end_ts-start_ts.
//  2. All 4 assert start every cycle -> grants in order 0,1,2,3,0,... with ids 0..7. Then
//     all ready=0 (full) until the first result is consumed.
//  3. Full table; result id=5 consumed while req1 waits -> same cycle ready=0. Next cycle
//     req_start_ready[1]=1 with req_start_id=5.
//  4. res_ready of owner held 0 for 5 cycles -> res_valid stays 1 and ts_out_ready=0.
//     busy[id] stays set, and no other res_valid bit rises.
//  5. rst pulsed with 3 IDs busy -> next cycle all outputs 0; a new start gets id=0.
//  6. (TS_SCHED_CHECK_EN) req3 ends id=0 owned by req0 -> req_end_ready[3]=1, ts_end_valid=0,
//     sched_err=1 for 1 cycle; busy[0] unchanged.

Source files
------------

// File: rtl/ts_sched_pkg.sv
// Shared types for ts_req_scheduler: ID/requester-index/timestamp types and the result record.
package ts_sched_pkg;

  localparam int DEF_N_REQ = 4;
  localparam int DEF_ID_W  = 3;
  localparam int DEF_TS_W  = 8;

  typedef logic [DEF_ID_W-1:0]          id_t;
  typedef logic [$clog2(DEF_N_REQ)-1:0] req_idx_t;
  typedef logic [DEF_TS_W-1:0]          ts_t;

  typedef struct packed {
    id_t id;
    ts_t start_ts;
    ts_t end_ts;
    ts_t delta;
  } result_t;

endpackage

// File: rtl/ts_rr_arb.sv
// Round-robin arbiter: searches req starting at ptr and returns a one-hot grant plus its index.
module ts_rr_arb #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic found;
  int   k;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    k     = 0;
    for (int off = 0; off < N; off++) begin
      k = int'(ptr) + off;
      if (k >= N) k = k - N;
      if (!found && req[IW'(k)]) begin
        found = 1'b1;
        idx   = IW'(k);
      end
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_gnt
    assign gnt[gi] = found && (idx == IW'(gi));
  end

endmodule

// File: rtl/ts_req_scheduler.sv
// Shares one event_timestamper among N_REQ requesters: ID allocation, start/end RR arbitration,
// result routing to the ID owner. Optional end-request checking under `TS_SCHED_CHECK_EN.
module ts_req_scheduler
  import ts_sched_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int ID_W  = DEF_ID_W,
  parameter int TS_W  = DEF_TS_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_start_valid,
  output logic [N_REQ-1:0]      req_start_ready,
  output logic [ID_W-1:0]       req_start_id,
  input  logic [N_REQ-1:0]      req_end_valid,
  input  logic [N_REQ*ID_W-1:0] req_end_id,
  output logic [N_REQ-1:0]      req_end_ready,
  output logic [N_REQ-1:0]      res_valid,
  input  logic [N_REQ-1:0]      res_ready,
  output logic [ID_W-1:0]       res_id,
  output logic [TS_W-1:0]       res_start_ts,
  output logic [TS_W-1:0]       res_end_ts,
  output logic [TS_W-1:0]       res_delta,
  output logic                  ts_start_valid,
  input  logic                  ts_start_ready,
  output logic [ID_W-1:0]       ts_start_id,
  output logic                  ts_end_valid,
  input  logic                  ts_end_ready,
  output logic [ID_W-1:0]       ts_end_id,
  input  logic                  ts_out_valid,
  output logic                  ts_out_ready,
  input  logic [ID_W-1:0]       ts_out_id,
  input  logic [TS_W-1:0]       ts_out_start_ts,
  input  logic [TS_W-1:0]       ts_out_end_ts,
  input  logic [TS_W-1:0]       ts_out_delta,
  output logic                  sched_err
);

  localparam int N_ID  = 2 ** ID_W;
  localparam int IDX_W = $clog2(N_REQ);

  logic [N_ID-1:0]  busy_reg, busy_next;
  logic [IDX_W-1:0] owner_reg [N_ID];
  logic [IDX_W-1:0] ptr_s_reg, ptr_e_reg;

  logic [ID_W-1:0]  alloc_id;
  logic             have_free;
  logic [N_REQ-1:0] start_gnt, end_gnt;
  logic [IDX_W-1:0] start_idx, end_idx, res_owner;
  logic             start_fire, end_any, end_bad, end_accept, end_fire, res_fire;
  logic [ID_W-1:0]  end_id;

  // Lowest free ID wins; allocation always sees the busy vector before this cycle's free.
  always_comb begin
    alloc_id = '0;
    for (int i = N_ID - 1; i >= 0; i--) begin
      if (!busy_reg[i]) alloc_id = ID_W'(i);
    end
  end
  assign have_free = ~&busy_reg;

  ts_rr_arb #(.N(N_REQ)) u_start_arb (
    .req (req_start_valid & {N_REQ{have_free}}),
    .ptr (ptr_s_reg),
    .gnt (start_gnt),
    .idx (start_idx)
  );

  assign ts_start_valid  = have_free && (|req_start_valid);
  assign ts_start_id     = alloc_id;
  assign req_start_id    = alloc_id;
  assign req_start_ready = start_gnt & {N_REQ{ts_start_ready}};
  assign start_fire      = ts_start_valid && ts_start_ready;

  ts_rr_arb #(.N(N_REQ)) u_end_arb (
    .req (req_end_valid),
    .ptr (ptr_e_reg),
    .gnt (end_gnt),
    .idx (end_idx)
  );

  assign end_any = |req_end_valid;
  assign end_id  = req_end_id[int'(end_idx)*ID_W +: ID_W];

`ifdef TS_SCHED_CHECK_EN
  assign end_bad = !busy_reg[end_id] || (owner_reg[end_id] != end_idx);
`else
  assign end_bad = 1'b0;
`endif

  // An illegal end is swallowed here, so it is accepted regardless of the timestamper.
  assign end_accept    = end_bad || ts_end_ready;
  assign ts_end_valid  = end_any && !end_bad;
  assign ts_end_id     = end_id;
  assign req_end_ready = end_gnt & {N_REQ{end_accept}};
  assign end_fire      = end_any && end_accept;
  assign sched_err     = end_any && end_bad;

  assign res_owner    = owner_reg[ts_out_id];
  assign ts_out_ready = res_ready[res_owner];
  assign res_fire     = ts_out_valid && ts_out_ready;
  assign res_id       = ts_out_id;
  assign res_start_ts = ts_out_start_ts;
  assign res_end_ts   = ts_out_end_ts;
  assign res_delta    = ts_out_delta;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_res
    assign res_valid[gi] = ts_out_valid && (res_owner == IDX_W'(gi));
  end

  // Set and clear never target the same ID: alloc picks a free ID, results free a busy one.
  for (genvar gi = 0; gi < N_ID; gi++) begin : g_busy
    assign busy_next[gi] = (start_fire && (alloc_id == ID_W'(gi))) ||
                           (busy_reg[gi] && !(res_fire && (ts_out_id == ID_W'(gi))));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_reg  <= '0;
      ptr_s_reg <= '0;
      ptr_e_reg <= '0;
      for (int i = 0; i < N_ID; i++) owner_reg[i] <= '0;
    end else begin
      busy_reg <= busy_next;
      if (start_fire) begin
        owner_reg[alloc_id] <= start_idx;
        ptr_s_reg <= (start_idx == IDX_W'(N_REQ - 1)) ? '0 : start_idx + 1'b1;
      end
      if (end_fire) begin
        ptr_e_reg <= (end_idx == IDX_W'(N_REQ - 1)) ? '0 : end_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ts_req_scheduler.sv
// Directed bench for ts_req_scheduler; the bench plays the timestamper side directly.
module tb_ts_req_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_start_valid, req_start_ready;
  logic [2:0]  req_start_id;
  logic [3:0]  req_end_valid, req_end_ready;
  logic [11:0] req_end_id;
  logic [3:0]  res_valid, res_ready;
  logic [2:0]  res_id;
  logic [7:0]  res_start_ts, res_end_ts, res_delta;
  logic        ts_start_valid, ts_start_ready;
  logic [2:0]  ts_start_id;
  logic        ts_end_valid, ts_end_ready;
  logic [2:0]  ts_end_id;
  logic        ts_out_valid, ts_out_ready;
  logic [2:0]  ts_out_id;
  logic [7:0]  ts_out_start_ts, ts_out_end_ts, ts_out_delta;
  logic        sched_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ts_req_scheduler dut (
    .clk(clk), .rst(rst),
    .req_start_valid(req_start_valid), .req_start_ready(req_start_ready),
    .req_start_id(req_start_id),
    .req_end_valid(req_end_valid), .req_end_id(req_end_id), .req_end_ready(req_end_ready),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_start_ts(res_start_ts), .res_end_ts(res_end_ts), .res_delta(res_delta),
    .ts_start_valid(ts_start_valid), .ts_start_ready(ts_start_ready), .ts_start_id(ts_start_id),
    .ts_end_valid(ts_end_valid), .ts_end_ready(ts_end_ready), .ts_end_id(ts_end_id),
    .ts_out_valid(ts_out_valid), .ts_out_ready(ts_out_ready), .ts_out_id(ts_out_id),
    .ts_out_start_ts(ts_out_start_ts), .ts_out_end_ts(ts_out_end_ts), .ts_out_delta(ts_out_delta),
    .sched_err(sched_err)
  );

  typedef struct {
    logic [3:0]  sv;
    logic [3:0]  ev;
    logic [11:0] eid;
    logic        tsr;
    logic        ter;
    logic        ov;
    logic [2:0]  oid;
    logic [3:0]  rr;
    logic [3:0]  e_srdy;
    logic [2:0]  e_sid;
    logic        e_tsv;
    logic [3:0]  e_erdy;
    logic        e_tev;
    logic [2:0]  e_teid;
    logic [3:0]  e_resv;
    logic        e_tor;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic [3:0] sv, input logic [3:0] ev, input logic [11:0] eid,
                      input logic tsr, input logic ter, input logic ov, input logic [2:0] oid,
                      input logic [3:0] rr);
    @(negedge clk);
    req_start_valid = sv;
    req_end_valid   = ev;
    req_end_id      = eid;
    ts_start_ready  = tsr;
    ts_end_ready    = ter;
    ts_out_valid    = ov;
    ts_out_id       = oid;
    res_ready       = rr;
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_start_valid = '0; req_end_valid = '0; req_end_id = '0;
    ts_start_ready = 1'b0; ts_end_ready = 1'b0; ts_out_valid = 1'b0;
    ts_out_id = '0; res_ready = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] exp_g;
    rst = 1'b1;
    ts_out_start_ts = 8'h10; ts_out_end_ts = 8'h1a; ts_out_delta = 8'h0a;

    //          sv       ev       eid     tsr  ter  ov   oid   rr    | srdy    sid   tsv  erdy    tev  teid  resv    tor
    vecs[0] = '{4'b0000, 4'b0000, 12'h000, 1'b0, 1'b0, 1'b0, 3'd0, 4'b0000, 4'b0000, 3'd0, 1'b0, 4'b0000, 1'b0, 3'd0, 4'b0000, 1'b0};
    vecs[1] = '{4'b0100, 4'b0000, 12'h000, 1'b1, 1'b0, 1'b0, 3'd0, 4'b0000, 4'b0100, 3'd0, 1'b1, 4'b0000, 1'b0, 3'd0, 4'b0000, 1'b0};
    vecs[2] = '{4'b0100, 4'b0000, 12'h000, 1'b0, 1'b0, 1'b0, 3'd0, 4'b0000, 4'b0000, 3'd1, 1'b1, 4'b0000, 1'b0, 3'd0, 4'b0000, 1'b0};
    vecs[3] = '{4'b0100, 4'b0000, 12'h000, 1'b1, 1'b0, 1'b0, 3'd0, 4'b0000, 4'b0100, 3'd1, 1'b1, 4'b0000, 1'b0, 3'd0, 4'b0000, 1'b0};
    vecs[4] = '{4'b0000, 4'b0100, 12'h000, 1'b0, 1'b1, 1'b0, 3'd0, 4'b0000, 4'b0000, 3'd2, 1'b0, 4'b0100, 1'b1, 3'd0, 4'b0000, 1'b0};
    vecs[5] = '{4'b0000, 4'b0000, 12'h000, 1'b0, 1'b0, 1'b1, 3'd0, 4'b0100, 4'b0000, 3'd2, 1'b0, 4'b0000, 1'b0, 3'd0, 4'b0100, 1'b1};
    vecs[6] = '{4'b0001, 4'b0000, 12'h000, 1'b1, 1'b0, 1'b0, 3'd0, 4'b0000, 4'b0001, 3'd0, 1'b1, 4'b0000, 1'b0, 3'd0, 4'b0000, 1'b0};
    vecs[7] = '{4'b0000, 4'b0000, 12'h000, 1'b0, 1'b0, 1'b1, 3'd1, 4'b1011, 4'b0000, 3'd2, 1'b0, 4'b0000, 1'b0, 3'd0, 4'b0100, 1'b0};
    vecs[8] = '{4'b0000, 4'b0101, 12'h040, 1'b0, 1'b1, 1'b0, 3'd0, 4'b0000, 4'b0000, 3'd2, 1'b0, 4'b0001, 1'b1, 3'd0, 4'b0000, 1'b0};
    vecs[9] = '{4'b0000, 4'b0100, 12'h040, 1'b0, 1'b0, 1'b0, 3'd0, 4'b0000, 4'b0000, 3'd2, 1'b0, 4'b0000, 1'b1, 3'd1, 4'b0000, 1'b0};

    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(vecs[i].sv, vecs[i].ev, vecs[i].eid, vecs[i].tsr, vecs[i].ter, vecs[i].ov,
           vecs[i].oid, vecs[i].rr);
      $display("vec %0d: srdy=%b sid=%0d erdy=%b teid=%0d resv=%b tor=%b", i,
               req_start_ready, req_start_id, req_end_ready, ts_end_id, res_valid, ts_out_ready);
      chk($sformatf("v%0d srdy", i), 32'(req_start_ready), 32'(vecs[i].e_srdy));
      chk($sformatf("v%0d sid", i),  32'(req_start_id),    32'(vecs[i].e_sid));
      chk($sformatf("v%0d tsv", i),  32'(ts_start_valid),  32'(vecs[i].e_tsv));
      chk($sformatf("v%0d erdy", i), 32'(req_end_ready),   32'(vecs[i].e_erdy));
      chk($sformatf("v%0d tev", i),  32'(ts_end_valid),    32'(vecs[i].e_tev));
      chk($sformatf("v%0d teid", i), 32'(ts_end_id),       32'(vecs[i].e_teid));
      chk($sformatf("v%0d resv", i), 32'(res_valid),       32'(vecs[i].e_resv));
      chk($sformatf("v%0d tor", i),  32'(ts_out_ready),    32'(vecs[i].e_tor));
      chk($sformatf("v%0d err", i),  32'(sched_err),       32'(0));
    end

    // All four requesters start every cycle: RR order 0,1,2,3 with ids 0..7, then full.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      step(4'hf, 4'h0, 12'h0, 1'b1, 1'b0, 1'b0, 3'd0, 4'h0);
      exp_g = 4'b0001 << (k % 4);
      $display("fill %0d: srdy=%b sid=%0d", k, req_start_ready, req_start_id);
      chk($sformatf("fill%0d srdy", k), 32'(req_start_ready), 32'(exp_g));
      chk($sformatf("fill%0d sid", k),  32'(req_start_id),    32'(k));
    end
    for (int k = 0; k < 2; k++) begin
      step(4'hf, 4'h0, 12'h0, 1'b1, 1'b0, 1'b0, 3'd0, 4'h0);
      $display("full %0d: srdy=%b tsv=%b", k, req_start_ready, ts_start_valid);
      chk("full srdy", 32'(req_start_ready), 32'(0));
      chk("full tsv",  32'(ts_start_valid),  32'(0));
    end

    // Result id 5 consumed while req1 waits: freed ID usable only next cycle.
    ts_out_start_ts = 8'h33; ts_out_end_ts = 8'h40; ts_out_delta = 8'h0d;
    step(4'b0010, 4'h0, 12'h0, 1'b1, 1'b0, 1'b1, 3'd5, 4'b0010);
    $display("free5: srdy=%b resv=%b tor=%b res_id=%0d delta=%0h", req_start_ready, res_valid,
             ts_out_ready, res_id, res_delta);
    chk("free5 srdy",  32'(req_start_ready), 32'(0));
    chk("free5 resv",  32'(res_valid),       32'(4'b0010));
    chk("free5 tor",   32'(ts_out_ready),    32'(1));
    chk("free5 resid", 32'(res_id),          32'(5));
    chk("free5 start", 32'(res_start_ts),    32'(8'h33));
    chk("free5 end",   32'(res_end_ts),      32'(8'h40));
    chk("free5 delta", 32'(res_delta),       32'(8'h0d));
    step(4'b0010, 4'h0, 12'h0, 1'b1, 1'b0, 1'b0, 3'd0, 4'h0);
    $display("realloc5: srdy=%b sid=%0d", req_start_ready, req_start_id);
    chk("realloc5 srdy", 32'(req_start_ready), 32'(4'b0010));
    chk("realloc5 sid",  32'(req_start_id),    32'(5));

    // Owner of id 2 (req2) stalls its result for 5 cycles; table stays full.
    for (int k = 0; k < 5; k++) begin
      step(4'b0001, 4'h0, 12'h0, 1'b1, 1'b0, 1'b1, 3'd2, 4'b0000);
      $display("stall %0d: resv=%b tor=%b srdy=%b", k, res_valid, ts_out_ready, req_start_ready);
      chk("stall resv", 32'(res_valid),       32'(4'b0100));
      chk("stall tor",  32'(ts_out_ready),    32'(0));
      chk("stall srdy", 32'(req_start_ready), 32'(0));
      chk("stall tsv",  32'(ts_start_valid),  32'(0));
    end
    step(4'b0001, 4'h0, 12'h0, 1'b1, 1'b0, 1'b1, 3'd2, 4'b0100);
    $display("release2: tor=%b srdy=%b", ts_out_ready, req_start_ready);
    chk("release2 tor",  32'(ts_out_ready),    32'(1));
    chk("release2 srdy", 32'(req_start_ready), 32'(0));
    step(4'b0001, 4'h0, 12'h0, 1'b1, 1'b0, 1'b0, 3'd0, 4'h0);
    $display("realloc2: srdy=%b sid=%0d", req_start_ready, req_start_id);
    chk("realloc2 srdy", 32'(req_start_ready), 32'(4'b0001));
    chk("realloc2 sid",  32'(req_start_id),    32'(2));

    // Reset with the table full: everything forgotten, allocation restarts at id 0.
    do_reset();
    step(4'h0, 4'h0, 12'h0, 1'b0, 1'b0, 1'b0, 3'd0, 4'h0);
    $display("post_rst: srdy=%b tsv=%b erdy=%b tev=%b resv=%b err=%b", req_start_ready,
             ts_start_valid, req_end_ready, ts_end_valid, res_valid, sched_err);
    chk("rst srdy", 32'(req_start_ready), 32'(0));
    chk("rst tsv",  32'(ts_start_valid),  32'(0));
    chk("rst erdy", 32'(req_end_ready),   32'(0));
    chk("rst tev",  32'(ts_end_valid),    32'(0));
    chk("rst resv", 32'(res_valid),       32'(0));
    chk("rst err",  32'(sched_err),       32'(0));
    step(4'b1000, 4'h0, 12'h0, 1'b1, 1'b0, 1'b0, 3'd0, 4'h0);
    $display("rst_alloc: srdy=%b sid=%0d", req_start_ready, req_start_id);
    chk("rst_alloc srdy", 32'(req_start_ready), 32'(4'b1000));
    chk("rst_alloc sid",  32'(req_start_id),    32'(0));

    // req0 takes id 1, then req3 tries to end id 1.
    step(4'b0001, 4'h0, 12'h0, 1'b1, 1'b0, 1'b0, 3'd0, 4'h0);
    chk("own1 srdy", 32'(req_start_ready), 32'(4'b0001));
    chk("own1 sid",  32'(req_start_id),    32'(1));
    step(4'h0, 4'b1000, 12'h200, 1'b0, 1'b1, 1'b0, 3'd0, 4'h0);
    $display("foreign_end: erdy=%b tev=%b teid=%0d err=%b", req_end_ready, ts_end_valid,
             ts_end_id, sched_err);
    chk("fend erdy", 32'(req_end_ready), 32'(4'b1000));
`ifdef TS_SCHED_CHECK_EN
    chk("fend tev",  32'(ts_end_valid),  32'(0));
    chk("fend err",  32'(sched_err),     32'(1));
`else
    chk("fend tev",  32'(ts_end_valid),  32'(1));
    chk("fend teid", 32'(ts_end_id),     32'(1));
    chk("fend err",  32'(sched_err),     32'(0));
`endif
    step(4'b0010, 4'h0, 12'h0, 1'b1, 1'b0, 1'b0, 3'd0, 4'h0);
    $display("after_fend: err=%b srdy=%b sid=%0d", sched_err, req_start_ready, req_start_id);
    chk("afend err",  32'(sched_err),       32'(0));
    chk("afend srdy", 32'(req_start_ready), 32'(4'b0010));
    chk("afend sid",  32'(req_start_id),    32'(2));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
